// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared arbiter FSM state type
package mem_port_arbiter_pkg;
    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin pick; first valid requester after ptr, searching ptr+1, ptr+2, ... mod NREQ
//   valid : request vector
//   ptr   : last winner
//   grant : one-hot winner (zero when nothing valid)
//   idx   : winner index (0 when nothing valid)
module rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]         valid,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);
    localparam int IW = $clog2(NREQ);
    // Scan from the farthest candidate back to the nearest so the nearest valid one wins.
    always_comb begin
        idx = '0;
        for (int i = NREQ; i >= 1; i--)
            if (valid[(int'(ptr) + i) % NREQ]) idx = IW'((int'(ptr) + i) % NREQ);
        grant = |valid ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter with locked bursts sharing one data memory port
//   i_clk, i_reset_n              : clock, async active-low reset
//   i_req_valid/lock/wren         : per-requester request controls
//   i_req_addr/wdata/bmask        : per-requester packed request payloads
//   o_req_ready                   : one-hot grant, beat accepted on valid&ready
//   o_mem_addr/wdata/bmask/wren   : registered memory port drive
//   i_mem_rdata                   : memory read data for o_mem_addr
//   o_rsp_valid, o_rsp_rdata      : one-hot response strobe one cycle after acceptance, read data
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int NREQ      = 3,
    parameter int MAX_BURST = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ-1:0]          i_req_lock,
    input  logic [NREQ-1:0]          i_req_wren,
    input  logic [NREQ*ADDR_W-1:0]   i_req_addr,
    input  logic [NREQ*32-1:0]       i_req_wdata,
    input  logic [NREQ*4-1:0]        i_req_bmask,
    output logic [NREQ-1:0]          o_req_ready,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [31:0]              o_mem_wdata,
    output logic [3:0]               o_mem_bmask,
    output logic                     o_mem_wren,
    input  logic [31:0]              i_mem_rdata,
    output logic [NREQ-1:0]          o_rsp_valid,
    output logic [31:0]              o_rsp_rdata
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e      state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [CW-1:0]   beat_cnt;
    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   win;
    logic            accept;
    logic            release_now;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .valid (i_req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Ready only ever asserts alongside valid, so any ready bit means an accepted beat.
    always_comb begin
        win         = state == ARB_IDLE ? pick_idx : owner;
        o_req_ready = !i_reset_n ? '0 :
                      state == ARB_IDLE ? pick_grant :
                      i_req_valid[owner] ? NREQ'(1) << owner : '0;
        accept      = |o_req_ready;
        release_now = !i_req_valid[owner] || !i_req_lock[owner] || int'(beat_cnt) + 1 == MAX_BURST;
        o_rsp_rdata = |o_rsp_valid ? i_mem_rdata : '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= ARB_IDLE;
            rr_ptr      <= IW'(NREQ - 1);
            owner       <= '0;
            beat_cnt    <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_bmask <= '0;
            o_mem_wren  <= 1'b0;
            o_rsp_valid <= '0;
        end else begin
            o_rsp_valid <= o_req_ready;
            o_mem_wren  <= accept && i_req_wren[win];
            if (accept) begin
                o_mem_addr  <= i_req_addr[int'(win)*ADDR_W +: ADDR_W];
                o_mem_wdata <= i_req_wdata[int'(win)*32 +: 32];
                o_mem_bmask <= i_req_bmask[int'(win)*4 +: 4];
                rr_ptr      <= win;
            end
            if (state == ARB_IDLE) begin
                if (accept && i_req_lock[win] && MAX_BURST > 1) begin
                    state    <= ARB_BURST;
                    owner    <= win;
                    beat_cnt <= CW'(1);
                end
            end else if (release_now) begin
                state    <= ARB_IDLE;
                beat_cnt <= '0;
                rr_ptr   <= owner;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table-driven bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW = 8;

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic [2:0]    i_req_valid, i_req_lock, i_req_wren;
    logic [3*AW-1:0] i_req_addr;
    logic [95:0]   i_req_wdata;
    logic [11:0]   i_req_bmask;
    logic [2:0]    o_req_ready;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [3:0]    o_mem_bmask;
    logic          o_mem_wren;
    logic [31:0]   i_mem_rdata;
    logic [2:0]    o_rsp_valid;
    logic [31:0]   o_rsp_rdata;

    logic [31:0]   mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(.ADDR_W(AW), .NREQ(3), .MAX_BURST(8)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_req_valid (i_req_valid),
        .i_req_lock  (i_req_lock),
        .i_req_wren  (i_req_wren),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .i_req_bmask (i_req_bmask),
        .o_req_ready (o_req_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_bmask (o_mem_bmask),
        .o_mem_wren  (o_mem_wren),
        .i_mem_rdata (i_mem_rdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata)
    );

    assign i_mem_rdata = mem[o_mem_addr];

    always @(posedge i_clk) begin
        if (!i_reset_n) begin
            mem[8'h10] <= 32'hDEADBEEF;
            mem[8'h20] <= 32'hCAFE0000;
            mem[8'h21] <= 32'hCAFE1111;
            mem[8'h22] <= 32'hCAFE2222;
            mem[8'h30] <= 32'h11223344;
        end else if (o_mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (o_mem_bmask[b]) mem[o_mem_addr][b*8 +: 8] <= o_mem_wdata[b*8 +: 8];
        end
    end

    typedef struct {
        logic [2:0] valid;
        logic [2:0] lock;
        logic [2:0] ready;
        logic [2:0] rsp;
    } vec_t;

    vec_t tbl [24];

    function automatic vec_t mk(logic [2:0] v, logic [2:0] l, logic [2:0] r, logic [2:0] s);
        vec_t t;
        t.valid = v;
        t.lock  = l;
        t.ready = r;
        t.rsp   = s;
        return t;
    endfunction

    function automatic logic [31:0] exp_rdata(logic [2:0] rsp);
        return rsp == 3'b001 ? 32'hCAFE0000 :
               rsp == 3'b010 ? 32'hCAFE1111 :
               rsp == 3'b100 ? 32'hCAFE2222 : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    initial begin
        // Three-way rotation, then a locked burst from req1 forced out after 8 beats,
        // a burst dropped by the owner going invalid, and a burst ended by lock=0.
        tbl[0] = mk(3'b111, 3'b000, 3'b001, 3'b000);
        tbl[1] = mk(3'b111, 3'b000, 3'b010, 3'b001);
        tbl[2] = mk(3'b111, 3'b000, 3'b100, 3'b010);
        tbl[3] = mk(3'b111, 3'b000, 3'b001, 3'b100);
        tbl[4] = mk(3'b111, 3'b000, 3'b010, 3'b001);
        tbl[5] = mk(3'b111, 3'b000, 3'b100, 3'b010);
        tbl[6] = mk(3'b010, 3'b010, 3'b010, 3'b100);
        for (int i = 7; i <= 13; i++) tbl[i] = mk(3'b111, 3'b010, 3'b010, 3'b010);
        tbl[14] = mk(3'b111, 3'b010, 3'b100, 3'b010);
        tbl[15] = mk(3'b111, 3'b010, 3'b001, 3'b100);
        tbl[16] = mk(3'b111, 3'b010, 3'b010, 3'b001);
        tbl[17] = mk(3'b101, 3'b000, 3'b000, 3'b010);
        tbl[18] = mk(3'b101, 3'b000, 3'b100, 3'b000);
        tbl[19] = mk(3'b000, 3'b000, 3'b000, 3'b100);
        tbl[20] = mk(3'b001, 3'b001, 3'b001, 3'b000);
        tbl[21] = mk(3'b011, 3'b000, 3'b001, 3'b001);
        tbl[22] = mk(3'b011, 3'b000, 3'b010, 3'b001);
        tbl[23] = mk(3'b000, 3'b000, 3'b000, 3'b010);

        i_reset_n   = 1'b0;
        i_req_valid = 3'b111;
        i_req_lock  = 3'b000;
        i_req_wren  = 3'b000;
        i_req_addr  = {8'h22, 8'h21, 8'h20};
        i_req_wdata = '0;
        i_req_bmask = '0;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        chk("reset_ready", 32'(o_req_ready), 32'h0);
        chk("reset_rsp", 32'(o_rsp_valid), 32'h0);
        chk("reset_wren", 32'(o_mem_wren), 32'h0);

        @(negedge i_clk);
        i_reset_n   = 1'b1;
        i_req_valid = 3'b001;
        i_req_addr  = {8'h22, 8'h21, 8'h10};
        #1;
        chk("read_ready", 32'(o_req_ready), 32'h1);
        @(negedge i_clk);
        i_req_valid = 3'b000;
        #1;
        chk("read_rsp", 32'(o_rsp_valid), 32'h1);
        chk("read_rdata", o_rsp_rdata, 32'hDEADBEEF);

        i_reset_n  = 1'b0;
        i_req_addr = {8'h22, 8'h21, 8'h20};
        @(negedge i_clk);
        i_reset_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            @(negedge i_clk);
            i_req_valid = tbl[i].valid;
            i_req_lock  = tbl[i].lock;
            #1;
            chk($sformatf("row%0d_ready", i), 32'(o_req_ready), 32'(tbl[i].ready));
            chk($sformatf("row%0d_rsp", i), 32'(o_rsp_valid), 32'(tbl[i].rsp));
            chk($sformatf("row%0d_rdata", i), o_rsp_rdata, exp_rdata(tbl[i].rsp));
        end

        @(negedge i_clk);
        i_req_valid = 3'b001;
        i_req_wren  = 3'b001;
        i_req_addr  = {8'h22, 8'h21, 8'h30};
        i_req_wdata = {64'h0, 32'h00AB0000};
        i_req_bmask = 12'h004;
        #1;
        chk("wr_ready", 32'(o_req_ready), 32'h1);
        @(negedge i_clk);
        i_req_valid = 3'b000;
        i_req_wren  = 3'b000;
        #1;
        chk("wr_wren_hi", 32'(o_mem_wren), 32'h1);
        chk("wr_ack", 32'(o_rsp_valid), 32'h1);
        chk("wr_bmask", 32'(o_mem_bmask), 32'h4);
        chk("wr_wdata", o_mem_wdata, 32'h00AB0000);
        @(negedge i_clk);
        i_req_valid = 3'b001;
        #1;
        chk("wr_wren_lo", 32'(o_mem_wren), 32'h0);
        chk("rb_ready", 32'(o_req_ready), 32'h1);
        @(negedge i_clk);
        i_req_valid = 3'b000;
        #1;
        chk("rb_rdata", o_rsp_rdata, 32'h11AB3344);
        chk("rb_wren", 32'(o_mem_wren), 32'h0);

        @(negedge i_clk);
        i_req_valid = 3'b010;
        i_req_lock  = 3'b010;
        #1;
        chk("mid_ready", 32'(o_req_ready), 32'h2);
        @(posedge i_clk);
        #1;
        chk("mid_rsp_before", 32'(o_rsp_valid), 32'h2);
        i_reset_n = 1'b0;
        #1;
        chk("mid_rsp_reset", 32'(o_rsp_valid), 32'h0);
        chk("mid_ready_reset", 32'(o_req_ready), 32'h0);
        chk("mid_rdata_reset", o_rsp_rdata, 32'h0);
        @(negedge i_clk);
        i_reset_n   = 1'b1;
        i_req_valid = 3'b111;
        i_req_lock  = 3'b000;
        #1;
        chk("post_reset_ready", 32'(o_req_ready), 32'h1);
        chk("post_reset_rsp", 32'(o_rsp_valid), 32'h0);
        @(negedge i_clk);
        i_req_valid = 3'b000;
        #1;
        chk("post_reset_rsp2", 32'(o_rsp_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
